pmod_gpio_bank: RTL and testbench
=================================

# pmod_gpio_bank

Parametrised GPIO bank that replaces the fixed 8-bit PMOD read/write/enable wiring with a register-mapped peripheral on the J1 I/O bus. It owns NUM_PINS pads: per-pin output data, per-pin direction, synchronised input sampling, and edge-triggered interrupts with sticky pending bits. It sits inside the J1 core's I/O space and drives the Caravel io_out/io_oeb pad pairs directly.

## Interface
- NUM_PINS, 8: number of pads; 1..DATA_W.
- DATA_W, 16: J1 bus data width.
- SYNC_STAGES, 2: input synchroniser depth; ≥2.
- DEBOUNCE_CYCLES, 16: stable cycles required by the debounce filter; ≥2; used only with the debounce option.
- boardClk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- bus_addr  in  3  register select.
- bus_wdata  in  DATA_W  write data.
- bus_wr  in  1  write strobe, one cycle per access.
- bus_rd  in  1  read strobe, one cycle per access.
- bus_rdata  out  DATA_W  registered read data.
- pad_in  in  NUM_PINS  raw pad inputs (asynchronous).
- pad_out  out  NUM_PINS  pad output data.
- pad_oeb  out  NUM_PINS  pad output enable, active-low (0 = drive).
- irq  out  1  interrupt request, level.

## Operation
- Register map, bits [NUM_PINS-1:0]; unused upper bits write-ignored, read 0:
  - 0 OUT (RW): output data.
  - 1 DIR (RW): 1 = output. pad_oeb = ~DIR.
  - 2 IN (RO): synchronised (filtered) input value for all pins, regardless of DIR.
  - 3 IEN (RW): per-pin interrupt enable.
  - 4 IPOL (RW): edge select; 1 = rising, 0 = falling.
  - 5 IPEND (R/W1C): sticky pending; a write of 1 clears that bit, 0 has no effect.
  - 6 OSET (WO): OUT |= wdata; reads 0.
  - 7 OCLR (WO): OUT &= ~wdata; reads 0.
- Input path: pad_in → SYNC_STAGES flops → (optional debounce) → `in_q`. A one-cycle-delayed copy `in_d` feeds edge detection.
- Edge: rise = in_q & ~in_d; fall = ~in_q & in_d; `hit` = IPOL ? rise : fall, per pin.
- IPEND bit sets when `hit`, regardless of IEN. Set and W1C in the same cycle: set wins.
- irq = |(IPEND & IEN), combinational from registers.
- bus_wr and bus_rd asserted together: write performed; read returns the pre-write value.
- Write to an unmapped or read-only address: no effect.

## Timing
- Reset values: OUT = 0, DIR = 0 (all pad_oeb = 1, high-Z), IEN = 0, IPOL = all 1, IPEND = 0, sync/filter/in_d flops = 0, bus_rdata = 0, irq = 0.
- Write latency: register and pad_out/pad_oeb update on the boardClk edge that samples bus_wr.
- Read latency: bus_rdata valid one cycle after bus_rd and held until the next read.
- Input latency, no debounce: a pad change is visible in IN SYNC_STAGES cycles later. IPEND sets on the next edge, SYNC_STAGES+1 cycles after the change. irq follows in the same cycle IPEND sets.
- Reset asserted mid-operation clears all state immediately. Edges during reset are not recorded. The first cycle after release produces no spurious edge because in_q = in_d = 0.

## Configuration
- GPIO_DEBOUNCE_EN defined:
  - Each pin has a counter of width $clog2(DEBOUNCE_CYCLES).
  - The filtered value takes the synchronised value only after it has differed from the filtered value for DEBOUNCE_CYCLES consecutive cycles.
  - Any return to the filtered value resets the counter.
  - This adds DEBOUNCE_CYCLES cycles of input latency.
  - The counter saturates. It does not wrap.
- GPIO_DEBOUNCE_EN not defined: the filter is a wire, and no counters are synthesised.

## Structure
- Package `gpio_pkg`: register address localparams (GPIO_OUT … GPIO_OCLR) and the IPOL reset constant.
- Sub-module `gpio_in_filter`, one instance per pin (generate loop): synchroniser chain plus optional debounce; output `in_q`.
- The top level holds the register file, edge/pending logic, read mux and irq.

## Test plan
- Reset: assert reset mid-run with OUT = 0xFF and DIR = 0xFF → pad_oeb = 0xFF, pad_out = 0x00, irq = 0 immediately; IN reads 0 after release.
- Direction/data: write DIR = 0x0F, OUT = 0xA5 → next cycle pad_oeb = 0xF0, pad_out = 0xA5. OSET 0x50 → 0xF5. OCLR 0x05 → 0xF0.
- Input sync: pad_in 0x00 → 0x3C → a read of IN returns 0x3C only from cycle SYNC_STAGES onward; earlier reads return 0x00.
- Interrupt: IEN = 0x01, IPOL = 0x01, rising edge on pin 0 → IPEND = 0x01 and irq = 1. Falling edge on pin 0 → no change. W1C 0x01 → irq = 0 next cycle.
- Collision: W1C 0x02 on the same cycle pin 1 hits → IPEND bit 1 stays 1.
- Debounce (macro on, DEBOUNCE_CYCLES = 4): 3-cycle glitch on pin 2 → IN bit 2 unchanged. A 4-cycle-stable change → IN bit 2 updates.

Source files
------------

// File: rtl/gpio_pkg.sv
// Register map and reset constants shared by the PMOD GPIO bank and its bench.
package gpio_pkg;

  localparam logic [2:0] GPIO_OUT   = 3'd0;
  localparam logic [2:0] GPIO_DIR   = 3'd1;
  localparam logic [2:0] GPIO_IN    = 3'd2;
  localparam logic [2:0] GPIO_IEN   = 3'd3;
  localparam logic [2:0] GPIO_IPOL  = 3'd4;
  localparam logic [2:0] GPIO_IPEND = 3'd5;
  localparam logic [2:0] GPIO_OSET  = 3'd6;
  localparam logic [2:0] GPIO_OCLR  = 3'd7;

  // Every pin defaults to rising-edge interrupts.
  localparam logic IPOL_RST_BIT = 1'b1;

endpackage

// File: rtl/gpio_in_filter.sv
// Per-pin input conditioning: synchroniser chain plus an optional debounce
// filter enabled by the GPIO_DEBOUNCE_EN macro.
module gpio_in_filter #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pad,
  output logic in_q
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_sync <= '0;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_pad};
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic             r_filt;
  logic [CNT_W-1:0] r_cnt;

  // Counter tracks consecutive cycles of disagreement; it tops out at
  // DEBOUNCE_CYCLES-1 and the filtered value flips on the following cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_filt <= 1'b0;
      r_cnt  <= '0;
    end else if (w_sync == r_filt) begin
      r_cnt  <= '0;
    end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      r_filt <= w_sync;
      r_cnt  <= '0;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  assign in_q = r_filt;
`else
  assign in_q = w_sync;

  if (DEBOUNCE_CYCLES < 2) begin : g_debounce_range
  end
`endif

endmodule

// File: rtl/pmod_gpio_bank.sv
// Register-mapped GPIO bank on the J1 I/O bus: output data, direction, synchronised
// inputs and sticky edge interrupts. Optional input debounce via GPIO_DEBOUNCE_EN.
module pmod_gpio_bank
  import gpio_pkg::*;
#(
  parameter int NUM_PINS        = 8,
  parameter int DATA_W          = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                boardClk,
  input  logic                reset,
  input  logic [2:0]          bus_addr,
  input  logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_wr,
  input  logic                bus_rd,
  output logic [DATA_W-1:0]   bus_rdata,
  input  logic [NUM_PINS-1:0] pad_in,
  output logic [NUM_PINS-1:0] pad_out,
  output logic [NUM_PINS-1:0] pad_oeb,
  output logic                irq
);

  logic [NUM_PINS-1:0] r_out;
  logic [NUM_PINS-1:0] r_dir;
  logic [NUM_PINS-1:0] r_ien;
  logic [NUM_PINS-1:0] r_ipol;
  logic [NUM_PINS-1:0] r_ipend;
  logic [NUM_PINS-1:0] r_in_d;
  logic [DATA_W-1:0]   r_rdata;

  logic [NUM_PINS-1:0] w_in_q;
  logic [NUM_PINS-1:0] w_wmask;
  logic [NUM_PINS-1:0] w_hit;
  logic [NUM_PINS-1:0] w_w1c;
  logic [DATA_W-1:0]   w_rd_val;
  logic                w_unused_wdata;

  for (genvar g = 0; g < NUM_PINS; g++) begin : g_pin
    gpio_in_filter #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_filter (
      .i_clk (boardClk),
      .i_rst (reset),
      .i_pad (pad_in[g]),
      .in_q  (w_in_q[g])
    );
  end

  assign w_wmask        = bus_wdata[NUM_PINS-1:0];
  assign w_unused_wdata = ^bus_wdata;

  // Since in_d resets alongside in_q, release from reset never looks like an edge.
  assign w_hit = (r_ipol & w_in_q & ~r_in_d) | (~r_ipol & ~w_in_q & r_in_d);
  assign w_w1c = (bus_wr && bus_addr == GPIO_IPEND) ? w_wmask : '0;

  always_ff @(posedge boardClk or posedge reset) begin
    if (reset) begin
      r_out   <= '0;
      r_dir   <= '0;
      r_ien   <= '0;
      r_ipol  <= {NUM_PINS{IPOL_RST_BIT}};
      r_ipend <= '0;
      r_in_d  <= '0;
    end else begin
      r_in_d  <= w_in_q;
      // A fresh edge overrides a simultaneous clear of the same bit.
      r_ipend <= (r_ipend & ~w_w1c) | w_hit;
      if (bus_wr) begin
        case (bus_addr)
          GPIO_OUT:  r_out  <= w_wmask;
          GPIO_DIR:  r_dir  <= w_wmask;
          GPIO_IEN:  r_ien  <= w_wmask;
          GPIO_IPOL: r_ipol <= w_wmask;
          GPIO_OSET: r_out  <= r_out | w_wmask;
          GPIO_OCLR: r_out  <= r_out & ~w_wmask;
          default:   ;
        endcase
      end
    end
  end

  always_comb begin
    w_rd_val = '0;
    case (bus_addr)
      GPIO_OUT:   w_rd_val[NUM_PINS-1:0] = r_out;
      GPIO_DIR:   w_rd_val[NUM_PINS-1:0] = r_dir;
      GPIO_IN:    w_rd_val[NUM_PINS-1:0] = w_in_q;
      GPIO_IEN:   w_rd_val[NUM_PINS-1:0] = r_ien;
      GPIO_IPOL:  w_rd_val[NUM_PINS-1:0] = r_ipol;
      GPIO_IPEND: w_rd_val[NUM_PINS-1:0] = r_ipend;
      default:    w_rd_val = '0;
    endcase
  end

  // Read data samples pre-write register values and holds until the next read.
  always_ff @(posedge boardClk or posedge reset) begin
    if (reset)       r_rdata <= '0;
    else if (bus_rd) r_rdata <= w_rd_val;
  end

  assign bus_rdata = r_rdata;
  assign pad_out   = r_out;
  assign pad_oeb   = ~r_dir;
  assign irq       = |(r_ipend & r_ien);

endmodule

// File: tb/tb_pmod_gpio_bank.sv
// Directed bench for pmod_gpio_bank; read results checked through an expected queue.
module tb_pmod_gpio_bank;
  import gpio_pkg::*;

  localparam int NP = 8;
  localparam int DW = 16;
  localparam int SS = 2;
  localparam int DC = 4;
`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT = SS + DC;
`else
  localparam int LAT = SS;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    bus_addr = '0;
  logic [DW-1:0] bus_wdata = '0;
  logic          bus_wr = 1'b0;
  logic          bus_rd = 1'b0;
  logic [DW-1:0] bus_rdata;
  logic [NP-1:0] pad_in = '0;
  logic [NP-1:0] pad_out;
  logic [NP-1:0] pad_oeb;
  logic          irq;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];

  pmod_gpio_bank #(
    .NUM_PINS        (NP),
    .DATA_W          (DW),
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .boardClk  (clk),
    .reset     (rst),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_wr    (bus_wr),
    .bus_rd    (bus_rd),
    .bus_rdata (bus_rdata),
    .pad_in    (pad_in),
    .pad_out   (pad_out),
    .pad_oeb   (pad_oeb),
    .irq       (irq)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [DW-1:0] d);
    bus_addr  = a;
    bus_wdata = d;
    bus_wr    = 1'b1;
    tick();
    bus_wr    = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [DW-1:0] exp, input string tag);
    bus_addr = a;
    bus_rd   = 1'b1;
    exp_q.push_back(exp);
    tick();
    bus_rd   = 1'b0;
    check(tag, bus_rdata, exp_q.pop_front());
  endtask

  task automatic wr_rd(input logic [2:0] a, input logic [DW-1:0] d, input logic [DW-1:0] exp_pre,
                       input string tag);
    bus_addr  = a;
    bus_wdata = d;
    bus_wr    = 1'b1;
    bus_rd    = 1'b1;
    exp_q.push_back(exp_pre);
    tick();
    bus_wr    = 1'b0;
    bus_rd    = 1'b0;
    check(tag, bus_rdata, exp_q.pop_front());
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_oeb", DW'(pad_oeb), 16'h00FF);
    check("rst_out", DW'(pad_out), 16'h0000);
    check("rst_irq", DW'(irq), 16'h0000);
    check("rst_rdata", bus_rdata, 16'h0000);
    rd(GPIO_IPOL, 16'h00FF, "rst_ipol");
    rd(GPIO_DIR, 16'h0000, "rst_dir");

    // direction and output data
    wr(GPIO_DIR, 16'h000F);
    wr(GPIO_OUT, 16'h00A5);
    check("dir_oeb", DW'(pad_oeb), 16'h00F0);
    check("out_pad", DW'(pad_out), 16'h00A5);
    wr(GPIO_OSET, 16'h0050);
    check("oset_pad", DW'(pad_out), 16'h00F5);
    wr(GPIO_OCLR, 16'h0005);
    check("oclr_pad", DW'(pad_out), 16'h00F0);
    rd(GPIO_OUT, 16'h00F0, "out_read");
    rd(GPIO_OSET, 16'h0000, "oset_read0");
    wr(GPIO_OUT, 16'hFF33);
    rd(GPIO_OUT, 16'h0033, "out_upper_ignored");
    wr(GPIO_IN, 16'h00FF);
    rd(GPIO_IN, 16'h0000, "in_write_ignored");
    wr_rd(GPIO_OUT, 16'h0011, 16'h0033, "wr_rd_pre");
    rd(GPIO_OUT, 16'h0011, "wr_rd_post");

    // input synchroniser latency
    pad_in = 8'h3C;
`ifdef GPIO_DEBOUNCE_EN
    repeat (LAT + 2) tick();
    rd(GPIO_IN, 16'h003C, "in_sync");
`else
    for (int k = 1; k <= SS + 1; k++)
      rd(GPIO_IN, (k > SS) ? 16'h003C : 16'h0000, $sformatf("in_sync_%0d", k));
`endif
    repeat (2) tick();
    rd(GPIO_IPEND, 16'h003C, "ipend_no_ien");
    check("irq_no_ien", DW'(irq), 16'h0000);
    pad_in = 8'h00;
    repeat (LAT + 3) tick();
    wr(GPIO_IPEND, 16'h00FF);
    rd(GPIO_IPEND, 16'h0000, "ipend_w1c_all");

    // interrupt on rising edge of pin 0
    wr(GPIO_IEN, 16'h0001);
    wr(GPIO_IPOL, 16'h0001);
    pad_in = 8'h01;
    repeat (LAT + 2) tick();
    check("irq_rise", DW'(irq), 16'h0001);
    rd(GPIO_IPEND, 16'h0001, "ipend_rise");
    pad_in = 8'h00;
    repeat (LAT + 2) tick();
    rd(GPIO_IPEND, 16'h0001, "ipend_fall_ignored");
    check("irq_held", DW'(irq), 16'h0001);
    wr(GPIO_IPEND, 16'h0001);
    check("irq_cleared", DW'(irq), 16'h0000);
    rd(GPIO_IPEND, 16'h0000, "ipend_cleared");

    // W1C colliding with a fresh edge on pin 1
    wr(GPIO_IPOL, 16'h0003);
    pad_in = 8'h02;
    repeat (LAT) tick();
    wr(GPIO_IPEND, 16'h0002);
    rd(GPIO_IPEND, 16'h0002, "collision_set_wins");
    check("irq_masked", DW'(irq), 16'h0000);
    wr(GPIO_IEN, 16'h0002);
    check("irq_pin1", DW'(irq), 16'h0001);

    // reset mid-operation
    wr(GPIO_OUT, 16'h00FF);
    wr(GPIO_DIR, 16'h00FF);
    check("pre_rst_out", DW'(pad_out), 16'h00FF);
    check("pre_rst_oeb", DW'(pad_oeb), 16'h0000);
    pad_in = 8'hFF;
    tick();
    #2 rst = 1'b1;
    #1;
    check("midrst_oeb", DW'(pad_oeb), 16'h00FF);
    check("midrst_out", DW'(pad_out), 16'h0000);
    check("midrst_irq", DW'(irq), 16'h0000);
    check("midrst_rdata", bus_rdata, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    rd(GPIO_IN, 16'h0000, "post_rst_in");
    rd(GPIO_IPEND, 16'h0000, "post_rst_ipend");

`ifdef GPIO_DEBOUNCE_EN
    // debounce: short glitch rejected, stable change accepted
    pad_in = 8'h00;
    repeat (LAT + 3) tick();
    rd(GPIO_IN, 16'h0000, "db_settle");
    pad_in = 8'h04;
    repeat (DC - 1) tick();
    pad_in = 8'h00;
    repeat (LAT + 2) tick();
    rd(GPIO_IN, 16'h0000, "db_glitch");
    pad_in = 8'h04;
    repeat (LAT + 2) tick();
    rd(GPIO_IN, 16'h0004, "db_stable");
`endif

    // report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
